instr_issue_encoder: RTL and testbench

- Host-side counterpart of the core's instruction decoder.
- Accepts field-level instruction requests and checks the opcode.
- Packs each legal request into the 32-bit IR word layout the execute core decodes, buffers it in a small FIFO, and issues words to the core over a valid/ready handshake.
- Replaces direct IR writes as the single instruction source feeding the core.

---
 rtl/instr_pkg.sv | 49 ++++
 rtl/ir_fifo.sv | 63 ++++++
 rtl/instr_issue_encoder.sv | 84 ++++++++
 tb/tb_instr_issue_encoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Opcode map, IR field positions and the canonical IR packing function
// shared by the issue encoder and anything that needs to build IR words.
package instr_pkg;

  localparam logic [4:0] OP_MOVSGPR    = 5'd0;
  localparam logic [4:0] OP_MOV        = 5'd1;
  localparam logic [4:0] OP_ADD        = 5'd2;
  localparam logic [4:0] OP_SUB        = 5'd3;
  localparam logic [4:0] OP_MUL        = 5'd4;
  localparam logic [4:0] OP_OR         = 5'd5;
  localparam logic [4:0] OP_AND        = 5'd6;
  localparam logic [4:0] OP_XOR        = 5'd7;
  localparam logic [4:0] OP_XNOR       = 5'd8;
  localparam logic [4:0] OP_NAND       = 5'd9;
  localparam logic [4:0] OP_NOR        = 5'd10;
  localparam logic [4:0] OP_NOT        = 5'd11;
  localparam logic [4:0] OP_LAST_LEGAL = 5'd11;

  localparam int OP_MSB    = 31;
  localparam int RDST_MSB  = 26;
  localparam int RSRC1_MSB = 21;
  localparam int IMM_BIT   = 16;
  localparam int RSRC2_MSB = 15;
  localparam int ISRC_MSB  = 15;

  // Builds the IR word the core decodes. Fields an instruction does not use
  // are forced to zero so that equivalent requests always yield one word.
  function automatic logic [31:0] pack_ir(input logic [4:0]  op,
                                          input logic [4:0]  rdst,
                                          input logic [4:0]  rsrc1,
                                          input logic [4:0]  rsrc2,
                                          input logic        imm,
                                          input logic [15:0] isrc);
    logic [31:0] ir;
    ir = '0;
    ir[OP_MSB -: 5]   = op;
    ir[RDST_MSB -: 5] = rdst;
    if (op != OP_MOVSGPR) begin
      ir[RSRC1_MSB -: 5] = (op == OP_MOV && imm) ? 5'd0 : rsrc1;
      ir[IMM_BIT]        = imm;
      if (imm)
        ir[ISRC_MSB -: 16] = isrc;
      else if (op != OP_MOV && op != OP_NOT)
        ir[RSRC2_MSB -: 5] = rsrc2;
    end
    return ir;
  endfunction

endpackage

// File: rtl/ir_fifo.sv
// Small synchronous FIFO holding packed IR words between the request side
// and the core. The head word is read straight from storage.
module ir_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush, doPop;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign dout   = empty ? 32'd0 : mem[rdPtr_q];

  // An empty FIFO cannot pop, so a push into it only shows up next cycle.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Next pointer and occupancy values; pointers wrap at the power-of-two depth.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    if (doPush && !doPop)      count_d = count_q + CW'(1);
    else if (!doPush && doPop) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers; reset drops every buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents beyond the occupancy are never observed.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= din;
  end

endmodule

// File: rtl/instr_issue_encoder.sv
// Host-side instruction source for the core: checks opcodes, packs legal
// requests into IR words, buffers them and issues them on valid/ready.
module instr_issue_encoder
  import instr_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [4:0]       req_rdst,
  input  logic [4:0]       req_rsrc1,
  input  logic [4:0]       req_rsrc2,
  input  logic             req_imm,
  input  logic [15:0]      req_isrc,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [31:0]      ir_data,
  output logic             err_illegal,
  output logic [CW-1:0]    fifo_count,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] reject_cnt
);

  logic             readyEn_q;
  logic             errPulse_q, errPulse_d;
  logic [CNT_W-1:0] issuedCnt_q, issuedCnt_d;
  logic [CNT_W-1:0] rejectCnt_q, rejectCnt_d;
  logic             fifoFull, fifoEmpty;
  logic             accept, legal, push, pop;
  logic [31:0]      packedWord;

  // A full FIFO still accepts when the head leaves on the same edge.
  assign req_ready  = readyEn_q && (!fifoFull || ir_ready);
  assign accept     = req_valid && req_ready;
  assign legal      = (req_op <= OP_LAST_LEGAL);
  assign push       = accept && legal;
  assign pop        = !fifoEmpty && ir_ready;
  assign packedWord = pack_ir(req_op, req_rdst, req_rsrc1, req_rsrc2, req_imm, req_isrc);

  assign ir_valid    = !fifoEmpty;
  assign err_illegal = errPulse_q;
  assign issued_cnt  = issuedCnt_q;
  assign reject_cnt  = rejectCnt_q;

  ir_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .rst_n (sys_rst),
    .push  (push),
    .pop   (pop),
    .din   (packedWord),
    .dout  (ir_data),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifo_count)
  );

  // Rejection pulse and wrapping issue/reject counters.
  always_comb begin
    errPulse_d  = accept && !legal;
    issuedCnt_d = pop ? issuedCnt_q + CNT_W'(1) : issuedCnt_q;
    rejectCnt_d = (accept && !legal) ? rejectCnt_q + CNT_W'(1) : rejectCnt_q;
  end

  // Status registers; request side stays closed until the first edge after reset.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      readyEn_q   <= 1'b0;
      errPulse_q  <= 1'b0;
      issuedCnt_q <= '0;
      rejectCnt_q <= '0;
    end else begin
      readyEn_q   <= 1'b1;
      errPulse_q  <= errPulse_d;
      issuedCnt_q <= issuedCnt_d;
      rejectCnt_q <= rejectCnt_d;
    end
  end

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Directed bench for the instruction issue encoder: reset, packing,
// canonicalisation, illegal opcodes, back-pressure and mid-stream reset.
module tb_instr_issue_encoder;

  logic        clk;
  logic        sys_rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [4:0]  req_rdst;
  logic [4:0]  req_rsrc1;
  logic [4:0]  req_rsrc2;
  logic        req_imm;
  logic [15:0] req_isrc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic        err_illegal;
  logic [2:0]  fifo_count;
  logic [15:0] issued_cnt;
  logic [15:0] reject_cnt;

  int nCompared;
  int nMismatched;
  int expIssued;

  instr_issue_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rdst    (req_rdst),
    .req_rsrc1   (req_rsrc1),
    .req_rsrc2   (req_rsrc2),
    .req_imm     (req_imm),
    .req_isrc    (req_isrc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_data     (ir_data),
    .err_illegal (err_illegal),
    .fifo_count  (fifo_count),
    .issued_cnt  (issued_cnt),
    .reject_cnt  (reject_cnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present a request on the request port (stimulus only)
  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rdst,
                               input logic [4:0] rsrc1, input logic [4:0] rsrc2,
                               input logic imm, input logic [15:0] isrc);
    req_valid = 1'b1;
    req_op    = op;
    req_rdst  = rdst;
    req_rsrc1 = rsrc1;
    req_rsrc2 = rsrc2;
    req_imm   = imm;
    req_isrc  = isrc;
  endtask

  task automatic clearReq();
    req_valid = 1'b0;
    req_op    = 5'd0;
    req_rdst  = 5'd0;
    req_rsrc1 = 5'd0;
    req_rsrc2 = 5'd0;
    req_imm   = 1'b0;
    req_isrc  = 16'd0;
  endtask

  task automatic test_reset();
    sys_rst  = 1'b0;
    ir_ready = 1'b0;
    clearReq();
    repeat (2) @(negedge clk);
    nCompared++;
    if (req_ready !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready);
    end
    nCompared++;
    if ({ir_valid, err_illegal, fifo_count, issued_cnt, reject_cnt, ir_data} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state: valid=%b err=%b cnt=%0d iss=%0d rej=%0d data=%h want all 0",
               ir_valid, err_illegal, fifo_count, issued_cnt, reject_cnt, ir_data);
    end
    sys_rst = 1'b1;
    @(negedge clk);
    nCompared++;
    if (req_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL post_reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_imm_add();
    ir_ready = 1'b1;
    applyStimulus(5'd2, 5'd0, 5'd2, 5'd0, 1'b1, 16'd4);
    @(negedge clk);
    clearReq();
    nCompared++;
    if (ir_valid !== 1'b1 || ir_data !== 32'h1005_0004) begin
      nMismatched++;
      $display("[TB] FAIL imm_add_word: valid=%b data=%h want valid=1 data=10050004", ir_valid, ir_data);
    end
    @(negedge clk);
    expIssued++;
    nCompared++;
    if (issued_cnt !== 16'(expIssued) || ir_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL imm_add_issue: issued=%0d valid=%b want issued=%0d valid=0", issued_cnt, ir_valid, expIssued);
    end
  endtask

  task automatic test_reg_add();
    ir_ready = 1'b1;
    applyStimulus(5'd2, 5'd0, 5'd4, 5'd5, 1'b0, 16'hFFFF);
    @(negedge clk);
    clearReq();
    nCompared++;
    if (ir_valid !== 1'b1 || ir_data !== 32'h1008_2800) begin
      nMismatched++;
      $display("[TB] FAIL reg_add_word: valid=%b data=%h want valid=1 data=10082800", ir_valid, ir_data);
    end
    @(negedge clk);
    expIssued++;
  endtask

  task automatic test_illegal();
    ir_ready = 1'b1;
    applyStimulus(5'd13, 5'd1, 5'd2, 5'd3, 1'b0, 16'd0);
    @(negedge clk);
    clearReq();
    nCompared++;
    if (err_illegal !== 1'b1 || reject_cnt !== 16'd1) begin
      nMismatched++;
      $display("[TB] FAIL illegal_pulse: err=%b rej=%0d want err=1 rej=1", err_illegal, reject_cnt);
    end
    nCompared++;
    if (ir_valid !== 1'b0 || fifo_count !== 3'd0) begin
      nMismatched++;
      $display("[TB] FAIL illegal_enqueue: valid=%b cnt=%0d want valid=0 cnt=0", ir_valid, fifo_count);
    end
    @(negedge clk);
    nCompared++;
    if (err_illegal !== 1'b0 || reject_cnt !== 16'd1) begin
      nMismatched++;
      $display("[TB] FAIL illegal_one_cycle: err=%b rej=%0d want err=0 rej=1", err_illegal, reject_cnt);
    end
  endtask

  task automatic test_canon();
    ir_ready = 1'b1;
    applyStimulus(5'd0, 5'd3, 5'd7, 5'd9, 1'b0, 16'h1234);
    @(negedge clk);
    clearReq();
    nCompared++;
    if (ir_data !== 32'h00C0_0000) begin
      nMismatched++; $display("[TB] FAIL canon_movsgpr: data=%h want 00c00000", ir_data);
    end
    @(negedge clk);
    applyStimulus(5'd11, 5'd0, 5'd6, 5'd16, 1'b0, 16'hBEEF);
    @(negedge clk);
    clearReq();
    nCompared++;
    if (ir_data !== 32'h580C_0000) begin
      nMismatched++; $display("[TB] FAIL canon_not: data=%h want 580c0000", ir_data);
    end
    @(negedge clk);
    applyStimulus(5'd1, 5'd1, 5'd5, 5'd3, 1'b1, 16'hABCD);
    @(negedge clk);
    clearReq();
    nCompared++;
    if (ir_data !== 32'h0841_ABCD) begin
      nMismatched++; $display("[TB] FAIL canon_movi: data=%h want 0841abcd", ir_data);
    end
    @(negedge clk);
    expIssued += 3;
    nCompared++;
    if (issued_cnt !== 16'(expIssued)) begin
      nMismatched++; $display("[TB] FAIL canon_issued: got %0d want %0d", issued_cnt, expIssued);
    end
  endtask

  // Words used here: ADD immediate, rdst=k, isrc=k
  function automatic logic [31:0] bpWord(input int k);
    return 32'h1001_0000 | (32'(k) << 22) | 32'(k);
  endfunction

  task automatic test_back_pressure();
    ir_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(5'd2, 5'(k), 5'd0, 5'd0, 1'b1, 16'(k));
      nCompared++;
      if (req_ready !== 1'b1) begin
        nMismatched++; $display("[TB] FAIL bp_ready_fill%0d: got %b want 1", k, req_ready);
      end
      @(negedge clk);
    end
    applyStimulus(5'd2, 5'd5, 5'd0, 5'd0, 1'b1, 16'd5);
    nCompared++;
    if (req_ready !== 1'b0 || fifo_count !== 3'd4 || ir_data !== bpWord(1)) begin
      nMismatched++;
      $display("[TB] FAIL bp_full: ready=%b cnt=%0d data=%h want ready=0 cnt=4 data=%h",
               req_ready, fifo_count, ir_data, bpWord(1));
    end
    @(negedge clk);
    nCompared++;
    if (ir_valid !== 1'b1 || fifo_count !== 3'd4 || ir_data !== bpWord(1)) begin
      nMismatched++;
      $display("[TB] FAIL bp_hold: valid=%b cnt=%0d data=%h want valid=1 cnt=4 data=%h",
               ir_valid, fifo_count, ir_data, bpWord(1));
    end
    ir_ready = 1'b1;
    #1;
    nCompared++;
    if (req_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL bp_full_pop_ready: got %b want 1", req_ready);
    end
    @(negedge clk);
    clearReq();
    nCompared++;
    if (fifo_count !== 3'd4 || ir_data !== bpWord(2)) begin
      nMismatched++;
      $display("[TB] FAIL bp_push_pop: cnt=%0d data=%h want cnt=4 data=%h", fifo_count, ir_data, bpWord(2));
    end
    for (int j = 3; j <= 5; j++) begin
      @(negedge clk);
      nCompared++;
      if (fifo_count !== 3'(6 - j) || ir_data !== bpWord(j)) begin
        nMismatched++;
        $display("[TB] FAIL bp_drain%0d: cnt=%0d data=%h want cnt=%0d data=%h",
                 j, fifo_count, ir_data, 6 - j, bpWord(j));
      end
    end
    @(negedge clk);
    expIssued += 5;
    nCompared++;
    if (ir_valid !== 1'b0 || fifo_count !== 3'd0 || issued_cnt !== 16'(expIssued)) begin
      nMismatched++;
      $display("[TB] FAIL bp_empty: valid=%b cnt=%0d issued=%0d want valid=0 cnt=0 issued=%0d",
               ir_valid, fifo_count, issued_cnt, expIssued);
    end
  endtask

  task automatic test_reset_midstream();
    ir_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(5'd3, 5'(k), 5'd1, 5'd2, 1'b0, 16'd0);
      @(negedge clk);
    end
    clearReq();
    nCompared++;
    if (fifo_count !== 3'd3) begin
      nMismatched++; $display("[TB] FAIL mid_queued: cnt=%0d want 3", fifo_count);
    end
    #2;
    sys_rst = 1'b0;
    #1;
    nCompared++;
    if (ir_valid !== 1'b0 || fifo_count !== 3'd0 || issued_cnt !== 16'd0 ||
        reject_cnt !== 16'd0 || req_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL mid_async_reset: valid=%b cnt=%0d iss=%0d rej=%0d ready=%b want 0 0 0 0 0",
               ir_valid, fifo_count, issued_cnt, reject_cnt, req_ready);
    end
    @(negedge clk);
    sys_rst  = 1'b1;
    ir_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nCompared++;
      if (ir_valid !== 1'b0 || issued_cnt !== 16'd0) begin
        nMismatched++;
        $display("[TB] FAIL mid_no_stale%0d: valid=%b issued=%0d want 0 0", c, ir_valid, issued_cnt);
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expIssued   = 0;
    test_reset();
    test_imm_add();
    test_reg_add();
    test_illegal();
    test_canon();
    test_back_pressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
